sequential_divider: RTL and testbench

// - Multi-cycle restoring divider: 2*DIM-bit dividend / DIM-bit divisor -> 2*DIM-bit quotient + DIM-bit remainder.
// - Inverse of the combinational Wallace-tree multiplier datapath: a 16-bit product divided by an 8-bit operand

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 23 ++
 rtl/sequential_divider.sv | 158 +++++++++++++++
 tb/tb_sequential_divider.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and FSM state type for the sequential divider
package div_pkg;

  localparam int DIV_DIM   = 8;
  localparam int DIV_CNT_W = $clog2(2 * DIV_DIM + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, trial subtract
module div_step #(
  parameter int DIM = 8
) (
  input  logic [DIM:0]   rem_i,
  input  logic           dvd_bit_i,
  input  logic [DIM-1:0] divisor_i,
  output logic [DIM:0]   rem_o,
  output logic           q_bit_o
);

  logic [DIM+1:0] shifted;
  logic [DIM:0]   diff;

  // Partial remainder stays below divisor, so the subtracted value always fits DIM+1 bits.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted[DIM:0] - {1'b0, divisor_i};
    q_bit_o = (shifted >= {2'b00, divisor_i});
    rem_o   = q_bit_o ? diff : shifted[DIM:0];
  end

endmodule

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional DIV_SIGNED_EN adds signed_op for two's-complement operands (truncating toward zero).
module sequential_divider
  import div_pkg::*;
#(
  parameter int DIM = DIV_DIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*DIM-1:0] dividend,
  input  logic [DIM-1:0]   divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [2*DIM-1:0] quotient,
  output logic [DIM-1:0]   remainder,
  output logic             div_by_zero
);

  localparam int QW    = 2 * DIM;
  localparam int CNT_W = $clog2(2 * DIM + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(QW - 1);

  div_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIM:0]   rem_q, rem_d;
  logic [QW-1:0]  dvd_q, dvd_d;
  logic [DIM-1:0] dsr_q, dsr_d;
  logic [QW-1:0]  quot_q, quot_d;
  logic [DIM-1:0] remd_q, remd_d;
  logic           dbz_q, dbz_d;

  logic [DIM:0]   step_rem;
  logic           step_q;
  logic [QW-1:0]  dvd_mag, q_raw, q_fin;
  logic [DIM-1:0] dsr_mag, r_raw, r_fin;

  div_step #(.DIM(DIM)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[QW-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  assign q_raw = {dvd_q[QW-2:0], step_q};
  assign r_raw = step_rem[DIM-1:0];

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic qneg_q, qneg_d, rneg_q, rneg_d;

  // The datapath divides magnitudes; signs are reapplied when the result is captured.
  assign a_neg   = signed_op & dividend[QW-1];
  assign b_neg   = signed_op & divisor[DIM-1];
  assign dvd_mag = a_neg ? -dividend : dividend;
  assign dsr_mag = b_neg ? -divisor : divisor;
  assign q_fin   = qneg_q ? -q_raw : q_raw;
  assign r_fin   = rneg_q ? -r_raw : r_raw;
`else
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
  assign q_fin   = q_raw;
  assign r_fin   = r_raw;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          rem_d = '0;
          dsr_d = dsr_mag;
          if (divisor == '0) begin
            state_d = FINISH;
            quot_d  = '1;
            remd_d  = dividend[DIM-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            dvd_d   = dvd_mag;
            dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
`endif
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = q_raw;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FINISH;
          quot_d  = q_fin;
          remd_d  = r_fin;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - directed-vector bench for sequential_divider
module tb_sequential_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;
`ifdef DIV_SIGNED_EN
  logic        signed_op = 1'b0;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sequential_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one start pulse; returns just after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                         input int elat);
    int lat;
    launch(a, b);
    check_eq({tag, " busy"}, busy, 1'b1);
    wait_done(lat);
    check_eq({tag, " latency"}, lat, elat);
    check_eq({tag, " quotient"}, quotient, eq);
    check_eq({tag, " remainder"}, remainder, er);
    check_eq({tag, " dbz"}, div_by_zero, edbz);
    check_eq({tag, " busy@done"}, busy, 1'b1);
    @(posedge clk); #1;
    check_eq({tag, " done pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int lat;
    int seen_done;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset outs", {busy, done, div_by_zero, quotient, remainder}, '0);
    rst = 1'b0;

    run_div("1000/7",    16'd1000,  8'd7,   16'd142,  8'd6,   1'b0, 16);
    run_div("100/0",     16'd100,   8'd0,   16'hFFFF, 8'h64,  1'b1, 0);
    run_div("0/5",       16'd0,     8'd5,   16'd0,    8'd0,   1'b0, 16);
    run_div("65535/255", 16'hFFFF,  8'd255, 16'd257,  8'd0,   1'b0, 16);
    run_div("65535/1",   16'hFFFF,  8'd1,   16'hFFFF, 8'd0,   1'b0, 16);
    run_div("254/255",   16'd254,   8'd255, 16'd0,    8'd254, 1'b0, 16);

    // start while busy is ignored; start during the done cycle is ignored too
    launch(16'd500, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd9; divisor = 8'd9;
    @(posedge clk); #1;
    start = 1'b0; dividend = '0; divisor = '0;
    wait_done(lat);
    check_eq("500/3 latency", lat, 11);
    check_eq("500/3 quotient", quotient, 16'd166);
    check_eq("500/3 remainder", remainder, 8'd2);
    start = 1'b1; dividend = 16'd9; divisor = 8'd9;
    @(posedge clk); #1;
    check_eq("done-cycle start ignored", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; dividend = '0; divisor = '0;
    check_eq("9/9 accepted", busy, 1'b1);
    wait_done(lat);
    check_eq("9/9 latency", lat, 16);
    check_eq("9/9 quotient", quotient, 16'd1);
    check_eq("9/9 remainder", remainder, 8'd0);
    @(posedge clk); #1;

    // reset mid-operation aborts without a done pulse
    launch(16'd1000, 8'd7);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort outs", {busy, done, div_by_zero, quotient, remainder}, '0);
    seen_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check_eq("abort no done", seen_done, 0);
    run_div("40/6", 16'd40, 8'd6, 16'd6, 8'd4, 1'b0, 16);

`ifdef DIV_SIGNED_EN
    signed_op = 1'b1;
    run_div("-100/7",     16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0, 16);
    run_div("-32768/-1",  16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 16);
    run_div("100/-7",     16'd100,  8'hF9, 16'hFFF2, 8'h02, 1'b0, 16);
    signed_op = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
